// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREGS x XLEN register file with write-through read ports and a busy-bit scoreboard
module regfile_scoreboard #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter int NREAD = 2,
   parameter int SP_IDX = 2,
   parameter logic [XLEN-1:0] SP_INIT = 32'h2ffc,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREAD*AW-1:0]   rs_addr,
   output logic [NREAD*XLEN-1:0] rs_data,
   output logic [NREAD-1:0]      rs_busy,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [XLEN-1:0]       wr_data,
   input  logic                  claim_en,
   input  logic [AW-1:0]         claim_addr,
   input  logic                  flush,
   input  logic [AW-1:0]         dbg_addr,
   output logic [XLEN-1:0]       dbg_data,
   output logic [NREGS-1:0]      busy_vec,
   output logic [AW:0]           busy_cnt
);
   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             wr_ok;

   assign wr_ok = wr_en && wr_addr != '0;

   // a claim wins over a same-cycle writeback: the younger writer still owns the register
   always_comb begin
      busy_d = flush ? '0 : busy_q;
      if (wr_en) busy_d[wr_addr] = 1'b0;
      if (claim_en) busy_d[claim_addr] = 1'b1;
      busy_d[0] = 1'b0;
      cnt_d = (AW+1)'($countones(busy_d));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
         busy_q <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_ok) regs_q[wr_addr] <= wr_data;
         busy_q <= busy_d;
         cnt_q <= cnt_d;
      end
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0] a;
      logic          byp, clm;
      assign a = rs_addr[k*AW +: AW];
      assign byp = wr_ok && wr_addr == a;
      assign clm = claim_en && claim_addr == a;
      assign rs_data[k*XLEN +: XLEN] = (a == '0) ? '0 : byp ? wr_data : regs_q[a];
      assign rs_busy[k] = a != '0 && busy_q[a] && !(byp && !clm);
   end

   assign dbg_data = regs_q[dbg_addr];
   assign busy_vec = busy_q;
   assign busy_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: randomized check of regfile_scoreboard against an array model, plus directed literal cases
module tb_regfile_scoreboard;
   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  rs_addr;
   logic [63:0] rs_data;
   logic [1:0]  rs_busy;
   logic        wr_en, claim_en, flush;
   logic [4:0]  wr_addr, claim_addr, dbg_addr;
   logic [31:0] wr_data, dbg_data, busy_vec;
   logic [5:0]  busy_cnt;

   logic [15:0]  rs_addr4;
   logic [127:0] rs_data4;
   logic [3:0]   rs_busy4, wr_addr4, claim_addr4, dbg_addr4;
   logic         wr_en4, claim_en4, flush4;
   logic [31:0]  wr_data4, dbg_data4;
   logic [15:0]  busy_vec4;
   logic [4:0]   busy_cnt4;

   int checks = 0, errors = 0;
   bit chk_en = 0;
   logic [31:0] m_reg [32];
   logic [31:0] m_bv;

   always #5 clk = ~clk;

   regfile_scoreboard dut (
      .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
      .claim_addr(claim_addr), .flush(flush), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .busy_vec(busy_vec), .busy_cnt(busy_cnt)
   );

   regfile_scoreboard #(.NREAD(4), .NREGS(16)) dut4 (
      .clk(clk), .reset(reset), .rs_addr(rs_addr4), .rs_data(rs_data4), .rs_busy(rs_busy4),
      .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .claim_en(claim_en4),
      .claim_addr(claim_addr4), .flush(flush4), .dbg_addr(dbg_addr4), .dbg_data(dbg_data4),
      .busy_vec(busy_vec4), .busy_cnt(busy_cnt4)
   );

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", n, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (a == 0) return 0;
      if (wr_en && wr_addr == a) return wr_data;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      bit written = wr_en && wr_addr == a;
      bit claimed = claim_en && claim_addr == a;
      return a != 0 && m_bv[a] && !(written && !claimed);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("rs_data%0d", k), rs_data[k*32 +: 32], exp_data(rs_addr[k*5 +: 5]));
            chk($sformatf("rs_busy%0d", k), rs_busy[k], exp_busy(rs_addr[k*5 +: 5]));
         end
         chk("dbg_data", dbg_data, m_reg[dbg_addr]);
         chk("busy_vec", busy_vec, m_bv);
         chk("busy_cnt", busy_cnt, $countones(m_bv));
      end
   end

   task automatic model_edge();
      if (reset) begin
         for (int i = 0; i < 32; i++) m_reg[i] = 0;
         m_reg[2] = 32'h2ffc;
         m_bv = 0;
      end else begin
         if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
         if (flush) m_bv = 0;
         else if (wr_en) m_bv[wr_addr] = 1'b0;
         if (claim_en) m_bv[claim_addr] = 1'b1;
         m_bv[0] = 1'b0;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      wr_en = 0; claim_en = 0; flush = 0; reset = 0;
   endtask

   function automatic logic [4:0] raddr();
      return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
   endfunction

   initial begin
      reset = 1; wr_en = 0; claim_en = 0; flush = 0;
      rs_addr = 0; wr_addr = 0; wr_data = 0; claim_addr = 0; dbg_addr = 0;
      wr_en4 = 0; claim_en4 = 0; flush4 = 0; rs_addr4 = 0; wr_addr4 = 0;
      wr_data4 = 0; claim_addr4 = 0; dbg_addr4 = 0;
      cyc();
      chk_en = 1;
      cyc();
      reset = 0;
      #1;
      chk("reset busy_vec", busy_vec, 0);
      chk("reset busy_cnt", busy_cnt, 0);
      for (int a = 0; a < 32; a++) begin
         dbg_addr = 5'(a);
         #1;
         chk($sformatf("reset dbg r%0d", a), dbg_data, (a == 2) ? 32'h2ffc : 32'h0);
      end
      cyc();
      // write-through bypass, storage only after the edge
      wr_en = 1; wr_addr = 5; wr_data = 32'hdeadbeef; rs_addr = {5'd0, 5'd5}; dbg_addr = 5;
      #1;
      chk("bypass rs_data0", rs_data[31:0], 32'hdeadbeef);
      chk("pre-edge dbg r5", dbg_data, 0);
      cyc();
      idle();
      #1;
      chk("post-edge dbg r5", dbg_data, 32'hdeadbeef);
      // register 0 ignores writes and claims
      wr_en = 1; wr_addr = 0; wr_data = 32'h1234; claim_en = 1; claim_addr = 0;
      rs_addr = 0; dbg_addr = 0;
      #1;
      chk("r0 read during write", rs_data[31:0], 0);
      cyc();
      idle();
      #1;
      chk("r0 dbg", dbg_data, 0);
      chk("r0 busy_vec", busy_vec, 0);
      chk("r0 busy_cnt", busy_cnt, 0);
      claim_en = 1; claim_addr = 7;
      cyc();
      idle(); rs_addr = {5'd7, 5'd0};
      #1;
      chk("r7 rs_busy1", rs_busy[1], 1);
      chk("r7 busy_cnt", busy_cnt, 1);
      wr_en = 1; wr_addr = 7; wr_data = 32'h55; claim_en = 1; claim_addr = 7;
      #1;
      chk("r7 busy during write+claim", rs_busy[1], 1);
      cyc();
      idle(); dbg_addr = 7;
      #1;
      chk("r7 still busy", busy_vec[7], 1);
      chk("r7 dbg", dbg_data, 32'h55);
      flush = 1;
      cyc();
      idle();
      claim_en = 1; claim_addr = 3; cyc();
      claim_addr = 4; cyc();
      claim_addr = 9; cyc();
      idle();
      #1;
      chk("three claims busy_cnt", busy_cnt, 3);
      chk("three claims busy_vec", busy_vec, 32'h0000_0218);
      flush = 1; claim_en = 1; claim_addr = 10;
      cyc();
      idle();
      #1;
      chk("flush+claim busy_vec", busy_vec, 32'h0000_0400);
      chk("flush+claim busy_cnt", busy_cnt, 1);
      // reset overrides claim and write in the same cycle
      reset = 1; claim_en = 1; claim_addr = 8; wr_en = 1; wr_addr = 2; wr_data = 0;
      cyc();
      idle(); dbg_addr = 2;
      #1;
      chk("reset-override busy_vec", busy_vec, 0);
      chk("reset-override r2", dbg_data, 32'h2ffc);
      for (int n = 0; n < 2000; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         wr_en = 1'($urandom_range(0, 1));
         wr_addr = raddr();
         wr_data = $urandom;
         claim_en = ($urandom_range(0, 2) == 0);
         claim_addr = raddr();
         flush = ($urandom_range(0, 19) == 0);
         rs_addr = {raddr(), raddr()};
         dbg_addr = raddr();
         cyc();
      end
      idle();
      cyc();
      // four-port, sixteen-register instance
      wr_en4 = 1; wr_addr4 = 11; wr_data4 = 32'hcafef00d;
      rs_addr4 = {4'd11, 4'd3, 4'd11, 4'd0}; dbg_addr4 = 11;
      #1;
      chk("n4 bypass port3", rs_data4[127:96], 32'hcafef00d);
      chk("n4 bypass port1", rs_data4[63:32], 32'hcafef00d);
      chk("n4 port2 r3", rs_data4[95:64], 0);
      chk("n4 pre-edge dbg", dbg_data4, 0);
      @(posedge clk); #1;
      wr_en4 = 0; claim_en4 = 1; claim_addr4 = 15;
      #1;
      chk("n4 stored port3", rs_data4[127:96], 32'hcafef00d);
      chk("n4 dbg r11", dbg_data4, 32'hcafef00d);
      @(posedge clk); #1;
      claim_en4 = 0; rs_addr4 = {4'd15, 4'd0, 4'd0, 4'd0};
      #1;
      chk("n4 busy port3", rs_busy4[3], 1);
      chk("n4 busy_vec", busy_vec4, 16'h8000);
      chk("n4 busy_cnt", busy_cnt4, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
